vga_multi_debug: RTL
====================

VGA_MULTI_DEBUG -- requirements
Module: vga_multi_debug

Interface
REQ-001 SHALL have parameter IMG_W, default 320, meaning per-channel image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 240, meaning per-channel image height in lines.
REQ-003 SHALL have parameter NUM_CH, default 3, meaning stored channel count (left/right/disparity), range 1..4.
REQ-004 SHALL have parameter PIX_W, default 8, meaning pixel width in bits.
REQ-005 SHALL have parameter BORDER_VAL, default 0, meaning pixel value returned outside any image.
REQ-006 SHALL have ports, one clock, synchronous active-high reset:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- in_ch  in  2  write channel index.
- in_x  in  10  write column.
- in_y  in  10  write row.
- in_val  in  PIX_W  write pixel.
- in_is_val  in  1  write strobe.
- freeze  in  1  level request to hold stored frames.
- disp_mode  in  1  0 = single channel, 1 = tiled.
- disp_ch  in  2  channel shown when disp_mode=0.
- pixel_req  in  1  display read strobe.
- pixel_x  in  10  display column.
- pixel_y  in  10  display row.
- pixel_val  out  PIX_W  read pixel.
- pixel_vld  out  1  pixel_val valid.
- frozen  out  1  writes currently blocked.
- frame_cnt  out  16  completed frames, wrapping.
- drop_cnt  out  16  rejected writes, saturating at 0xFFFF.

Function
REQ-007 Write accepted when in_is_val=1, in_ch<NUM_CH, in_x<IMG_W, in_y<IMG_H, and not blocked by freeze; addr = in_ch*IMG_W*IMG_H + in_y*IMG_W + in_x, width $clog2(NUM_CH*IMG_W*IMG_H).
REQ-008 Out-of-range write with in_is_val=1 SHALL be discarded and increment drop_cnt; freeze-blocked writes SHALL NOT count.
REQ-009 frame_cnt SHALL increment on an accepted write at (IMG_W-1, IMG_H-1) of channel 0; wraps 0xFFFF->0.
REQ-010 Mode 0: pixel maps to (disp_ch, pixel_x, pixel_y); in-range iff pixel_x<IMG_W, pixel_y<IMG_H, disp_ch<NUM_CH.
REQ-011 Mode 1: ch = pixel_x / IMG_W, x = pixel_x mod IMG_W, y = pixel_y; in-range iff ch<NUM_CH and pixel_y<IMG_H.
REQ-012 Read pipeline: pixel_vld SHALL assert exactly 2 cycles after pixel_req; one read per cycle, no back-pressure.
REQ-013 Out-of-range read SHALL return BORDER_VAL with pixel_vld still asserted at latency 2.
REQ-014 Same-cycle read and write to one address SHALL return the old data.
REQ-015 Freeze FSM states: RUN, FRZ_PEND, FROZEN, RES_PEND.
- RUN->FRZ_PEND on freeze=1.
- FRZ_PEND->FROZEN on an accepted write at (0,0) of channel 0; that write and all later writes are blocked.
- FROZEN->RES_PEND on freeze=0.
- RES_PEND->RUN on next in_is_val at (0,0) of channel 0; that write is accepted.
- freeze deasserted in FRZ_PEND returns to RUN; freeze reasserted in RES_PEND returns to FROZEN.
REQ-016 frozen SHALL be 1 in FROZEN and RES_PEND, registered.
REQ-017 disp_mode/disp_ch changes SHALL take effect on the next pixel_req, no glitch on in-flight reads.

Reset
REQ-018 On reset: FSM=RUN, pixel_vld=0, pixel_val=0, frozen=0, frame_cnt=0, drop_cnt=0.
REQ-019 RAM contents SHALL NOT be cleared; reset mid-read SHALL squash in-flight pixel_vld.

Configuration
REQ-020 Macro VGA_DEBUG_FREEZE_EN defined: freeze FSM per REQ-015.
REQ-021 Macro undefined: freeze ignored, frozen tied 0, all in-range writes accepted.

Structure
REQ-022 Package vga_debug_pkg SHALL hold the freeze state enum, mode encodings, and address-width function.
REQ-023 Sub-module dbg_frame_ram: single-clock, one write port, one registered read port, depth NUM_CH*IMG_W*IMG_H, width PIX_W.

Verification
REQ-024 Write ch1 (5,7)=0xA5; mode 0, disp_ch=1, read (5,7) -> pixel_vld 2 cycles later, pixel_val=0xA5.
REQ-025 Mode 1, read pixel_x=325, y=7 -> ch1 (5,7)=0xA5; pixel_x=960 with NUM_CH=3 -> BORDER_VAL.
REQ-026 Write in_x=320 and in_ch=3 -> drop_cnt=2, RAM unchanged; 65536 such writes -> drop_cnt holds 0xFFFF.
REQ-027 freeze=1 mid-frame -> writes continue until ch0 (0,0), then frozen=1 and data unchanged; freeze=0 -> writes resume at next ch0 (0,0).
REQ-028 Same-cycle write 0x11 over 0x22 and read same address -> 0x22, then next read 0x11; reset during read -> no pixel_vld.

Source files
------------

// File: rtl/vga_debug_pkg.sv
// Shared types for the multi-channel VGA debug viewer: freeze FSM states,
// display mode encodings and the frame-store address width helper.
package vga_debug_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FRZ_PEND  = 2'd1,
        ST_FROZEN    = 2'd2,
        ST_RES_PEND  = 2'd3
    } frz_state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_TILED  = 1'b1;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dbg_frame_ram.sv
// Single-clock frame store: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
module dbg_frame_ram #(
    parameter int DEPTH = 230400,
    parameter int PIX_W = 8,
    parameter int AW    = 18
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             re,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        if (re)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_multi_debug.sv
// Multi-channel debug frame viewer: stores NUM_CH images and serves display
// reads single or tiled. Optional freeze FSM built when VGA_DEBUG_FREEZE_EN is defined.
//
// state        | meaning
// ST_RUN       | writes flow normally
// ST_FRZ_PEND  | freeze requested, waiting for ch0 (0,0) to start the hold
// ST_FROZEN    | all writes blocked
// ST_RES_PEND  | freeze released, waiting for ch0 (0,0) to resume writing
module vga_multi_debug
    import vga_debug_pkg::*;
#(
    parameter int             IMG_W      = 320,
    parameter int             IMG_H      = 240,
    parameter int             NUM_CH     = 3,
    parameter int             PIX_W      = 8,
    parameter logic [PIX_W-1:0] BORDER_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       in_ch,
    input  logic [9:0]       in_x,
    input  logic [9:0]       in_y,
    input  logic [PIX_W-1:0] in_val,
    input  logic             in_is_val,
    input  logic             freeze,
    input  logic             disp_mode,
    input  logic [1:0]       disp_ch,
    input  logic             pixel_req,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    output logic [PIX_W-1:0] pixel_val,
    output logic             pixel_vld,
    output logic             frozen,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      drop_cnt
);

    localparam int DEPTH = NUM_CH * IMG_W * IMG_H;
    localparam int AW    = addr_width(DEPTH);

    logic          wr_in_range;
    logic          wr_origin;
    logic          wr_last;
    logic          wr_blocked;
    logic          wr_accept;
    logic [AW-1:0] wr_addr;

    assign wr_in_range = in_is_val && (32'(in_ch) < NUM_CH)
                         && (32'(in_x) < IMG_W) && (32'(in_y) < IMG_H);
    assign wr_origin   = in_is_val && (in_ch == 2'd0) && (in_x == 10'd0) && (in_y == 10'd0);
    assign wr_last     = (in_ch == 2'd0) && (32'(in_x) == IMG_W - 1) && (32'(in_y) == IMG_H - 1);
    assign wr_accept   = wr_in_range && !wr_blocked;
    assign wr_addr     = AW'(in_ch) * AW'(IMG_W * IMG_H) + AW'(in_y) * AW'(IMG_W) + AW'(in_x);

`ifdef VGA_DEBUG_FREEZE_EN
    frz_state_t frz_state;

    // The ch0 origin write that enters FROZEN is itself blocked, while the one
    // that leaves RES_PEND goes through, so the held frame stays whole.
    always_comb begin
        wr_blocked = 1'b0;
        case (frz_state)
            ST_RUN:      wr_blocked = 1'b0;
            ST_FRZ_PEND: wr_blocked = freeze && wr_origin;
            ST_FROZEN:   wr_blocked = 1'b1;
            ST_RES_PEND: wr_blocked = freeze || !wr_origin;
            default:     wr_blocked = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frz_state <= ST_RUN;
            frozen    <= 1'b0;
        end else begin
            case (frz_state)
                ST_RUN: begin
                    if (freeze)
                        frz_state <= ST_FRZ_PEND;
                end
                ST_FRZ_PEND: begin
                    if (!freeze) begin
                        frz_state <= ST_RUN;
                    end else if (wr_origin) begin
                        frz_state <= ST_FROZEN;
                        frozen    <= 1'b1;
                    end
                end
                ST_FROZEN: begin
                    if (!freeze)
                        frz_state <= ST_RES_PEND;
                end
                ST_RES_PEND: begin
                    if (freeze) begin
                        frz_state <= ST_FROZEN;
                    end else if (wr_origin) begin
                        frz_state <= ST_RUN;
                        frozen    <= 1'b0;
                    end
                end
                default: begin
                    frz_state <= ST_RUN;
                    frozen    <= 1'b0;
                end
            endcase
        end
    end
`else
    assign wr_blocked = 1'b0;
    assign frozen     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (wr_accept && wr_last)
                frame_cnt <= frame_cnt + 16'd1;
            if (in_is_val && !wr_in_range && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    logic [9:0]       rd_ch;
    logic [9:0]       rd_x;
    logic             rd_in_range;
    logic [AW-1:0]    rd_addr;
    logic [PIX_W-1:0] ram_q;
    logic             vld_s1;
    logic             oob_s1;

    // Mode and channel are sampled with the request, so later changes never
    // disturb reads already in the pipe.
    always_comb begin
        rd_ch       = '0;
        rd_x        = pixel_x;
        rd_in_range = 1'b0;
        if (disp_mode == MODE_TILED) begin
            rd_ch       = pixel_x / 10'(IMG_W);
            rd_x        = pixel_x % 10'(IMG_W);
            rd_in_range = (32'(rd_ch) < NUM_CH) && (32'(pixel_y) < IMG_H);
        end else begin
            rd_ch       = {8'd0, disp_ch};
            rd_x        = pixel_x;
            rd_in_range = (32'(pixel_x) < IMG_W) && (32'(pixel_y) < IMG_H)
                          && (32'(disp_ch) < NUM_CH);
        end
    end

    assign rd_addr = rd_in_range
                     ? AW'(rd_ch) * AW'(IMG_W * IMG_H) + AW'(pixel_y) * AW'(IMG_W) + AW'(rd_x)
                     : '0;

    dbg_frame_ram #(
        .DEPTH (DEPTH),
        .PIX_W (PIX_W),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (wr_accept),
        .wr_addr (wr_addr),
        .wr_data (in_val),
        .re      (pixel_req),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_s1    <= 1'b0;
            oob_s1    <= 1'b0;
            pixel_vld <= 1'b0;
            pixel_val <= '0;
        end else begin
            vld_s1    <= pixel_req;
            oob_s1    <= !rd_in_range;
            pixel_vld <= vld_s1;
            if (vld_s1)
                pixel_val <= oob_s1 ? BORDER_VAL : ram_q;
        end
    end

endmodule
